// File: rtl/inst_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package : loader_pkg
// Brief   : Shared types and constants for the instruction-memory loader.
// Rev     : 1.0
// ============================================================================
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_LO = 3'd1,
        CNT_HI = 3'd2,
        W_LO   = 3'd3,
        W_HI   = 3'd4,
        CHK    = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } loader_state_e;

    localparam int CNT_BYTES = 2;

endpackage
`default_nettype wire

// File: rtl/inst_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Interface : loader_if
// Brief     : Host byte stream in, instruction-RAM write port out.
// Rev       : 1.0
// ============================================================================
interface loader_if #(
    parameter int A = 10,
    parameter int W = 9
);
    logic [7:0]   In_Data;
    logic         In_Valid;
    logic         In_Ready;
    logic         Wr_En;
    logic [A-1:0] Wr_Addr;
    logic [W-1:0] Wr_Data;

    modport slave (
        input  In_Data, In_Valid,
        output In_Ready, Wr_En, Wr_Addr, Wr_Data
    );

    modport master (
        output In_Data, In_Valid,
        input  In_Ready, Wr_En, Wr_Addr, Wr_Data
    );
endinterface
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module : inst_mem_loader
// Brief  : Unpacks a counted, checksummed byte stream into instruction RAM.
// Rev    : 1.0
// ============================================================================
module inst_mem_loader
    import loader_pkg::*;
#(
    parameter int A = 10,
    parameter int W = 9
) (
    input  wire logic Clk,
    input  wire logic Reset_n,
    input  wire logic Start,
    loader_if.slave   bus,
    output logic      Busy,
    output logic      Done,
    output logic      Error
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_CNT_LO = CNT_LO;
    localparam logic [2:0] S_CNT_HI = CNT_HI;
    localparam logic [2:0] S_W_LO   = W_LO;
    localparam logic [2:0] S_W_HI   = W_HI;
    localparam logic [2:0] S_CHK    = CHK;
    localparam logic [2:0] S_DONE   = DONE;
    localparam logic [2:0] S_ERR    = ERR;

    localparam int          C_CW        = 8 * CNT_BYTES;
    localparam logic [A:0]  C_MAX_WORDS = {1'b1, {A{1'b0}}};
    localparam logic [A:0]  C_ONE       = {{A{1'b0}}, 1'b1};

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [7:0]      r_lo;
    logic [7:0]      r_chk;
    logic [A:0]      r_addr;
    logic [A:0]      r_count;
    logic            r_wr_en;
    logic [W-1:0]    r_wr_data;
    logic            r_done;
    logic            r_error;

    logic            w_busy;
    logic            w_xfer;
    logic            w_start;
    logic [C_CW-1:0] w_count;
    logic            w_oversize;
    logic            w_zero;
    logic [A:0]      w_addr_next;

    assign w_busy      = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) ||
                         (r_state == S_W_LO)   || (r_state == S_W_HI)   ||
                         (r_state == S_CHK);
    assign w_xfer      = bus.In_Valid & w_busy;
    assign w_start     = Start & ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (r_state == S_ERR));
    assign w_count     = {bus.In_Data, r_lo};
    assign w_oversize  = w_count > C_CW'(C_MAX_WORDS);
    assign w_zero      = (w_count == '0);
    assign w_addr_next = r_addr + C_ONE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (Start)  w_next = S_CNT_LO;
            S_CNT_LO: if (w_xfer) w_next = S_CNT_HI;
            S_CNT_HI: if (w_xfer) w_next = w_oversize ? S_ERR :
                                           w_zero     ? S_CHK : S_W_LO;
            S_W_LO:   if (w_xfer) w_next = S_W_HI;
            // r_addr already reflects any write still in flight from the previous word
            S_W_HI:   if (w_xfer) w_next = (w_addr_next == r_count) ? S_CHK : S_W_LO;
            S_CHK:    if (w_xfer) w_next = (bus.In_Data == r_chk) ? S_DONE : S_ERR;
            S_DONE,
            S_ERR:    w_next = Start ? S_CNT_LO : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_lo      <= '0;
            r_chk     <= '0;
            r_addr    <= '0;
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr_en <= 1'b0;
            if (r_wr_en) begin
                r_addr <= w_addr_next;
            end
            if (w_start) begin
                r_done  <= 1'b0;
                r_error <= 1'b0;
                r_addr  <= '0;
                r_chk   <= '0;
            end
            if (w_xfer && (r_state != S_CHK)) begin
                r_chk <= r_chk ^ bus.In_Data;
            end
            if (w_xfer) begin
                case (r_state)
                    S_CNT_LO, S_W_LO: r_lo <= bus.In_Data;
                    S_CNT_HI: begin
                        r_count <= w_count[A:0];
                        if (w_oversize) r_error <= 1'b1;
                    end
                    S_W_HI: begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= {bus.In_Data[W-9:0], r_lo};
                    end
                    S_CHK: begin
                        if (bus.In_Data == r_chk) r_done  <= 1'b1;
                        else                      r_error <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.In_Ready = w_busy;
    assign bus.Wr_En    = r_wr_en;
    assign bus.Wr_Addr  = r_addr[A-1:0];
    assign bus.Wr_Data  = r_wr_data;
    assign Busy         = w_busy;
    assign Done         = r_done;
    assign Error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_mem_loader
// Brief  : Directed self-checking bench for inst_mem_loader.
// Rev    : 1.0
// ============================================================================
module tb_inst_mem_loader;

    localparam int A = 10;
    localparam int W = 9;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done, error;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_wr  = 0;

    always #5 clk = ~clk;

    loader_if #(.A(A), .W(W)) bus();

    inst_mem_loader #(.A(A), .W(W)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .Start   (start),
        .bus     (bus),
        .Busy    (busy),
        .Done    (done),
        .Error   (error)
    );

    always @(negedge clk) if (bus.Wr_En === 1'b1) n_wr++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            bus.In_Valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.In_Data  = b;
        bus.In_Valid = 1'b1;
        t = 0;
        while (bus.In_Ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_wait", 32'(t), 32'd0);
        @(posedge clk);
        #1 bus.In_Valid = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [A-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        check({tag, "_en"},   32'(bus.Wr_En),   32'd1);
        check({tag, "_addr"}, 32'(bus.Wr_Addr), 32'(a));
        check({tag, "_data"}, 32'(bus.Wr_Data), 32'(d));
    endtask

    // Three-word reference load; ck selects the trailing checksum byte
    task automatic run_load(input logic [7:0] ck, input int maxgap, input bit poke);
        logic [7:0] s [9];
        int g;
        s = '{8'h03, 8'h00, 8'h1F, 8'h01, 8'h00, 8'h00, 8'hAB, 8'h01, ck};
        for (int i = 0; i < 9; i++) begin
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            send(s[i], g);
            if (poke && i == 2) pulse_start();
            if (i == 3) expect_write("w0", 10'd0, 9'h11F);
            if (i == 5) expect_write("w1", 10'd1, 9'h000);
            if (i == 7) expect_write("w2", 10'd2, 9'h1AB);
        end
    endtask

    initial begin
        int w0;
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.In_Valid = 1'b1;
        bus.In_Data  = 8'h5A;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.In_Ready), 32'd0);
        check("rst_wren",  32'(bus.Wr_En),    32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_done",  32'(done),         32'd0);
        check("rst_error", 32'(error),        32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(bus.In_Ready), 32'd0);
        check("idle_busy",  32'(busy),         32'd0);
        bus.In_Valid = 1'b0;

        // good load
        @(negedge clk);
        w0 = n_wr;
        pulse_start();
        check("ld_busy", 32'(busy), 32'd1);
        run_load(8'hB7, 0, 1'b0);
        check("ok_done",  32'(done),  32'd1);
        check("ok_error", 32'(error), 32'd0);
        check("ok_busy",  32'(busy),  32'd0);
        check("ok_nwr",   32'(n_wr - w0), 32'd3);
        @(negedge clk);
        check("ok_idle_ready", 32'(bus.In_Ready), 32'd0);
        check("ok_done_hold",  32'(done),         32'd1);

        // bad checksum
        w0 = n_wr;
        pulse_start();
        check("bad_done_clr", 32'(done), 32'd0);
        run_load(8'hB6, 0, 1'b0);
        check("bad_error", 32'(error), 32'd1);
        check("bad_done",  32'(done),  32'd0);
        check("bad_nwr",   32'(n_wr - w0), 32'd3);

        // Start in the ERR cycle is honoured; then an empty load
        pulse_start();
        check("errstart_error", 32'(error),        32'd0);
        check("errstart_ready", 32'(bus.In_Ready), 32'd1);
        w0 = n_wr;
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_nwr",  32'(n_wr - w0), 32'd0);
        @(negedge clk);
        pulse_start();
        check("empty_done_clr", 32'(done), 32'd0);

        // oversize count 1025
        send(8'h01, 0);
        send(8'h04, 0);
        check("big_error", 32'(error),        32'd1);
        check("big_ready", 32'(bus.In_Ready), 32'd0);
        check("big_busy",  32'(busy),         32'd0);
        check("big_nwr",   32'(n_wr - w0),    32'd0);

        // reset mid-word
        @(negedge clk);
        w0 = n_wr;
        pulse_start();
        send(8'h03, 0);
        send(8'h00, 0);
        send(8'h1F, 0);
        send(8'h01, 0);
        expect_write("rw0", 10'd0, 9'h11F);
        send(8'h00, 0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(bus.In_Ready), 32'd0);
        check("abort_busy",  32'(busy),         32'd0);
        check("abort_wren",  32'(bus.Wr_En),    32'd0);
        check("abort_done",  32'(done),         32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_nwr",  32'(n_wr - w0), 32'd1);
        check("abort_idle", 32'(busy),      32'd0);

        // gappy stream with a stray Start while busy
        w0 = n_wr;
        pulse_start();
        run_load(8'hB7, 5, 1'b1);
        check("gap_done",  32'(done),  32'd1);
        check("gap_error", 32'(error), 32'd0);
        check("gap_nwr",   32'(n_wr - w0), 32'd3);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
